// File: rtl/usb_pkg.sv
// Shared constants and state types for the USB device-end handshake responder.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  // SYNC 00000001 sent LSB first
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // encoding is {dp, dm}
  typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_K = 2'b01, LS_J = 2'b10} line_t;

  typedef enum logic [2:0] {RX_IDLE, RX_SYNC, RX_PID, RX_BODY, RX_DISCARD} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TURN, TX_SYNC, TX_PID, TX_EOP} tx_state_t;

  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_crc16_chk.sv
// Serial CRC16 (non-reflected form, bits in wire order); match flags the good residual.
module usb_crc16_chk
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic match
);

  logic [15:0] crc;
  logic        fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   crc <= CRC16_INIT;
    else if (clr) crc <= CRC16_INIT;
    else if (en)  crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

  assign match = (crc == CRC16_RESID);

endmodule

// File: rtl/usb_dev_handshaker.sv
// USB device-end receiver with ACK/NAK handshake reply.
// Define USB_DEV_NAK_EN to answer NAK when busy is high at EOP; otherwise always ACK.
module usb_dev_handshaker
  import usb_pkg::*;
#(
  parameter int TURNAROUND = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       dp_r,
  input  logic       dm_r,
  input  logic       busy,
  output logic       dp_w,
  output logic       dm_w,
  output logic       de,
  output logic [3:0] rx_pid,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       hs_sent
);

  line_t     sym, prev_sym;
  rx_state_t rx_state;
  tx_state_t tx_state;
  logic       bit_d, tx_active, is_data, data_ok, start_tx, take_bit;
  logic       crc_clr, crc_en, crc_match, se0_seen, stuff_err;
  logic [2:0] sync_cnt, pid_cnt, ones, bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] pid_sr;
  logic [3:0] hs_pid, turn_cnt;
  logic [4:0] tx_cnt;
  logic [15:0] tx_sr;

  always_comb begin
    sym = LS_SE0;
    if (dp_r)      sym = LS_J;
    else if (dm_r) sym = LS_K;
  end

  assign bit_d     = (sym == prev_sym);
  assign tx_active = (tx_state != TX_IDLE);
  assign is_data   = (pid_sr[3:0] == PID_DATA0) || (pid_sr[3:0] == PID_DATA1);
  // byte_cnt saturates at 2, so 2 means at least 16 body bits
  assign data_ok   = (bit_cnt == 3'd0) && (byte_cnt == 2'd2) && crc_match && !stuff_err;
  assign start_tx  = !tx_active && (rx_state == RX_BODY) && se0_seen && (sym == LS_J)
                     && is_data && data_ok;
  assign take_bit  = !tx_active && ((rx_state == RX_PID) || (rx_state == RX_BODY))
                     && !se0_seen && (sym != LS_SE0) && (ones != 3'd6);
  assign crc_en    = take_bit && (rx_state == RX_BODY);
  assign crc_clr   = (rx_state == RX_SYNC);

`ifdef USB_DEV_NAK_EN
  assign hs_pid = busy ? PID_NAK : PID_ACK;
`else
  logic unused_busy;
  assign unused_busy = busy;
  assign hs_pid      = PID_ACK;
`endif

  usb_crc16_chk u_crc (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (bit_d),
    .match (crc_match)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_state  <= RX_IDLE;
      prev_sym  <= LS_J;
      sync_cnt  <= '0;
      pid_cnt   <= '0;
      pid_sr    <= '0;
      ones      <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      se0_seen  <= 1'b0;
      stuff_err <= 1'b0;
      rx_pid    <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (tx_active) begin
        // our own drive and the turnaround gap are not host traffic
        rx_state <= RX_IDLE;
        prev_sym <= LS_J;
        se0_seen <= 1'b0;
      end else begin
        if (sym != LS_SE0) prev_sym <= sym;
        case (rx_state)
          RX_IDLE:
            if (sym == LS_K) begin
              rx_state <= RX_SYNC;
              sync_cnt <= 3'd1;
            end
          RX_SYNC:
            if (sym == LS_SE0) begin
              rx_state <= RX_DISCARD;
              se0_seen <= 1'b1;
            end else if (!bit_d && sync_cnt != 3'd7) begin
              sync_cnt <= sync_cnt + 3'd1;
            end else if (bit_d && sync_cnt == 3'd7) begin
              rx_state  <= RX_PID;
              pid_cnt   <= '0;
              ones      <= '0;
              stuff_err <= 1'b0;
            end else begin
              rx_state <= RX_DISCARD;
            end
          RX_PID, RX_BODY:
            if (se0_seen) begin
              if (sym == LS_J) begin
                rx_state <= RX_IDLE;
                se0_seen <= 1'b0;
                if (!is_data || data_ok) begin
                  rx_valid <= 1'b1;
                  rx_pid   <= pid_sr[3:0];
                end else begin
                  rx_err <= 1'b1;
                end
              end else if (sym == LS_K) begin
                rx_state <= RX_DISCARD;
                se0_seen <= 1'b0;
              end
            end else if (sym == LS_SE0) begin
              se0_seen <= 1'b1;
              if (rx_state == RX_PID || bit_cnt != 3'd0) rx_state <= RX_DISCARD;
            end else if (ones == 3'd6) begin
              // stuff slot: bit is dropped, a 1 here is flagged
              ones <= '0;
              if (bit_d) stuff_err <= 1'b1;
            end else begin
              ones <= bit_d ? ones + 3'd1 : 3'd0;
              if (rx_state == RX_PID) begin
                pid_sr  <= {bit_d, pid_sr[7:1]};
                pid_cnt <= pid_cnt + 3'd1;
                if (pid_cnt == 3'd7) begin
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  rx_state <= pid_ok({bit_d, pid_sr[7:1]}) ? RX_BODY : RX_DISCARD;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && byte_cnt != 2'd2) byte_cnt <= byte_cnt + 2'd1;
              end
            end
          RX_DISCARD:
            if (sym == LS_SE0) begin
              se0_seen <= 1'b1;
            end else if (se0_seen && sym == LS_J) begin
              rx_err   <= 1'b1;
              rx_state <= RX_IDLE;
              se0_seen <= 1'b0;
            end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state <= TX_IDLE;
      turn_cnt <= '0;
      tx_cnt   <= '0;
      tx_sr    <= '0;
      de       <= 1'b0;
      dp_w     <= 1'b1;
      dm_w     <= 1'b0;
      hs_sent  <= 1'b0;
    end else begin
      hs_sent <= 1'b0;
      case (tx_state)
        TX_IDLE:
          if (start_tx) begin
            tx_state <= TURN;
            turn_cnt <= 4'(TURNAROUND - 1);
            tx_sr    <= {~hs_pid, hs_pid, SYNC_BYTE};
          end
        TURN:
          if (turn_cnt == 4'd0) begin
            tx_state <= TX_SYNC;
            tx_cnt   <= '0;
            de       <= 1'b1;
            if (!tx_sr[0]) begin dp_w <= dm_w; dm_w <= dp_w; end
            tx_sr <= tx_sr >> 1;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        TX_SYNC, TX_PID:
          if (tx_cnt == 5'd15) begin
            tx_state <= TX_EOP;
            tx_cnt   <= 5'd16;
            dp_w     <= 1'b0;
            dm_w     <= 1'b0;
          end else begin
            // NRZI: a 0 toggles the line, a 1 holds it
            if (!tx_sr[0]) begin dp_w <= dm_w; dm_w <= dp_w; end
            tx_sr  <= tx_sr >> 1;
            tx_cnt <= tx_cnt + 5'd1;
            if (tx_cnt == 5'd7) tx_state <= TX_PID;
          end
        TX_EOP: begin
          tx_cnt <= tx_cnt + 5'd1;
          if (tx_cnt == 5'd17) begin
            dp_w    <= 1'b1;
            dm_w    <= 1'b0;
            hs_sent <= 1'b1;
          end else if (tx_cnt == 5'd18) begin
            tx_state <= TX_IDLE;
            de       <= 1'b0;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_dev_handshaker.sv
// Directed bench for usb_dev_handshaker: encodes host packets, checks framing and the handshake reply.
module tb_usb_dev_handshaker;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic dp_r = 1'b1, dm_r = 1'b0, busy = 1'b0;
  logic dp_w, dm_w, de, rx_valid, rx_err, hs_sent;
  logic [3:0] rx_pid;

  int errors = 0, checks = 0, cyc = 0;
  int pkt_id = 0, seen_id = 0;
  int rv_n = 0, rv_cyc = 0, err_n = 0, de_n = 0, de_first = 0, hs_cyc = 0;
  logic [3:0]  rv_pid = '0;
  logic [37:0] de_pat = '0;
  byte unsigned pl[$];

  usb_dev_handshaker #(.TURNAROUND(4)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .dp_r     (dp_r),
    .dm_r     (dm_r),
    .busy     (busy),
    .dp_w     (dp_w),
    .dm_w     (dm_w),
    .de       (de),
    .rx_pid   (rx_pid),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .hs_sent  (hs_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pkt_id != seen_id) begin
      seen_id <= pkt_id;
      rv_n <= 0; err_n <= 0; de_n <= 0; de_pat <= '0;
      hs_cyc <= -1000; rv_cyc <= -2000; de_first <= -3000; rv_pid <= '0;
    end else begin
      if (rx_valid) begin rv_n <= rv_n + 1; rv_cyc <= cyc; rv_pid <= rx_pid; end
      if (rx_err) err_n <= err_n + 1;
      if (de) begin
        if (de_n == 0) de_first <= cyc;
        if (de_n < 19) de_pat <= {de_pat[35:0], dp_w, dm_w};
        de_n <= de_n + 1;
      end
      if (hs_sent) hs_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] pat(input string s);
    logic [37:0] r;
    r = '0;
    for (int i = 0; i < 19; i++) begin
      if (s[i] == "J")      r = {r[35:0], 2'b10};
      else if (s[i] == "K") r = {r[35:0], 2'b01};
      else                  r = {r[35:0], 2'b00};
    end
    return r;
  endfunction

  // reflected USB CRC16 over one byte
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic dp, input logic dm);
    dp_r = dp;
    dm_r = dm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] pid_b, input bit add_crc, input bit flip_crc,
                          input bit bad_stuff);
    logic q[$];
    logic st[$];
    logic [15:0] c;
    logic [7:0] b;
    logic ln;
    int ones;
    bit used;
    for (int i = 0; i < 7; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 0; i < 8; i++) st.push_back(pid_b[i]);
    c = 16'hFFFF;
    foreach (pl[k]) begin
      b = pl[k];
      for (int i = 0; i < 8; i++) st.push_back(b[i]);
      c = crc_byte(c, b);
    end
    if (add_crc) begin
      c = ~c;
      if (flip_crc) c[3] = ~c[3];
      for (int i = 0; i < 16; i++) st.push_back(c[i]);
    end
    ones = 0;
    used = 1'b0;
    foreach (st[i]) begin
      q.push_back(st[i]);
      if (st[i]) begin
        ones++;
        if (ones == 6) begin
          q.push_back(bad_stuff && !used);
          used = bad_stuff;
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    ln = 1'b1;
    foreach (q[i]) begin
      if (!q[i]) ln = ~ln;
      drive(ln, ~ln);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  task automatic chk_reply(input string tag, input logic [3:0] pid, input string hs);
    chk({tag, "_valid_n"}, rv_n, 1);
    chk({tag, "_pid"}, rv_pid, pid);
    chk({tag, "_err_n"}, err_n, 0);
    chk({tag, "_de_start"}, de_first - rv_cyc, 4);
    chk({tag, "_de_len"}, de_n, 19);
    chk({tag, "_hs_at"}, hs_cyc - rv_cyc, 22);
    chk({tag, "_pattern"}, de_pat, pat({"KJKJKJKK", hs, "00J"}));
  endtask

  localparam string ACK_S = "JJKJJKKK";
  localparam string NAK_S = "JJKKKJJK";

  initial begin
    bit reached;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de", de, 0);
    chk("rst_line", {dp_w, dm_w}, 2'b10);
    chk("rst_pid", rx_pid, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_hs", hs_sent, 0);
    rst_b = 1'b1;
    idle(4);

    pkt_id++; pl = {8'hA5}; busy = 1'b0;
    send_pkt(8'hC3, 1'b1, 1'b0, 1'b0);
    idle(30);
    chk_reply("d0_ack", 4'h3, ACK_S);

    pkt_id++; busy = 1'b1;
    send_pkt(8'hC3, 1'b1, 1'b0, 1'b0);
    busy = 1'b0;
    idle(30);
`ifdef USB_DEV_NAK_EN
    chk_reply("d0_busy", 4'h3, NAK_S);
`else
    chk_reply("d0_busy", 4'h3, ACK_S);
`endif

    pkt_id++; pl = {8'h5C};
    send_pkt(8'h4B, 1'b1, 1'b1, 1'b0);
    idle(30);
    chk("crc_err_n", err_n, 1);
    chk("crc_valid_n", rv_n, 0);
    chk("crc_de_n", de_n, 0);

    pkt_id++; pl = {8'hFF};
    send_pkt(8'hC3, 1'b1, 1'b0, 1'b1);
    idle(30);
    chk("stuff_err_n", err_n, 1);
    chk("stuff_valid_n", rv_n, 0);
    chk("stuff_de_n", de_n, 0);

    pkt_id++; pl = {8'h12, 8'h34};
    send_pkt(8'hE1, 1'b0, 1'b0, 1'b0);
    idle(30);
    chk("tok_valid_n", rv_n, 1);
    chk("tok_pid", rv_pid, 4'h1);
    chk("tok_err_n", err_n, 0);
    chk("tok_de_n", de_n, 0);

    pkt_id++;
    drive(1'b0, 1'b1); drive(1'b1, 1'b0); drive(1'b0, 1'b1);
    drive(1'b0, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    idle(10);
    chk("syncse0_err_n", err_n, 1);
    chk("syncse0_valid_n", rv_n, 0);

    pkt_id++; pl = {8'hA5};
    send_pkt(8'hC3, 1'b1, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (de_n >= 10) reached = 1'b1;
      else drive(1'b1, 1'b0);
    end
    chk("rst_tx_reach_pid", reached, 1);
    rst_b = 1'b0;
    #1;
    chk("rst_tx_de", de, 0);
    chk("rst_tx_line", {dp_w, dm_w}, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(4);

    pkt_id++; pl = {8'hA5}; busy = 1'b0;
    send_pkt(8'hC3, 1'b1, 1'b0, 1'b0);
    idle(30);
    chk_reply("post_rst", 4'h3, ACK_S);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
